// File: rtl/ctrl_seq_mc.sv
// ctrl_seq_mc: multi-channel polyphase sequencer for the sample rate converter.
// Runs the loaded program once per channel in round-robin order, producing
// circular data-buffer addresses, coefficient addresses, MAC strobes and
// register-file writes, with valid/ready handshakes on samples and results.
module ctrl_seq_mc #(
    parameter int NUM_CH             = 2,
    parameter int INSTR_DEPTH        = 16,
    parameter int DATA_ADDR_WIDTH    = 6,
    parameter int COEF_ADDR_WIDTH    = 6,
    parameter int LEN_WIDTH          = 5,
    parameter int REGFILE_ADDR_WIDTH = 3,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PC_W        = $clog2(INSTR_DEPTH),
    localparam int INSTR_WIDTH = 2 + LEN_WIDTH + DATA_ADDR_WIDTH + COEF_ADDR_WIDTH + REGFILE_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            prog,
    input  logic                            prog_we,
    input  logic [PC_W-1:0]                 prog_addr,
    input  logic [INSTR_WIDTH-1:0]          prog_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            ram_wr,
    output logic                            mac_en,
    output logic                            mac_clr,
    output logic [CH_W+DATA_ADDR_WIDTH-1:0] data_addr,
    output logic [COEF_ADDR_WIDTH-1:0]      coef_addr,
    output logic                            rf_we,
    output logic [REGFILE_ADDR_WIDTH-1:0]   rf_addr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CH_W-1:0]                 out_ch,
    output logic                            busy,
    output logic                            err
);

    // Instruction field positions, MSB->LSB: lstg, upse, len, doff, cptr, rd
    localparam int RD_LSB   = 0;
    localparam int CPTR_LSB = RD_LSB + REGFILE_ADDR_WIDTH;
    localparam int DOFF_LSB = CPTR_LSB + COEF_ADDR_WIDTH;
    localparam int LEN_LSB  = DOFF_LSB + DATA_ADDR_WIDTH;
    localparam int UPSE_BIT = LEN_LSB + LEN_WIDTH;
    localparam int LSTG_BIT = UPSE_BIT + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_WAIT_IN = 3'd3,
        S_MAC     = 3'd4,
        S_STORE   = 3'd5,
        S_OUT     = 3'd6
    } state_t;

    state_t                       state_r;
    state_t                       next_state_s;
    state_t                       eoi_state_s;
    logic [INSTR_WIDTH-1:0]       mem_r [INSTR_DEPTH];
    logic [INSTR_WIDTH-1:0]       instr_r;
    logic [PC_W-1:0]              pc_r;
    logic [CH_W-1:0]              ch_r;
    logic [LEN_WIDTH-1:0]         k_r;
    logic [DATA_ADDR_WIDTH-1:0]   wptr_r [NUM_CH];
    logic                         err_r;

    logic                         lstg_s;
    logic                         upse_s;
    logic [LEN_WIDTH-1:0]         len_s;
    logic [DATA_ADDR_WIDTH-1:0]   doff_s;
    logic [COEF_ADDR_WIDTH-1:0]   cptr_s;
    logic [REGFILE_ADDR_WIDTH-1:0] rd_s;
    logic                         abort_s;
    logic                         end_instr_s;
    logic                         last_pc_s;
    logic                         last_tap_s;
    logic [DATA_ADDR_WIDTH-1:0]   cur_wptr_s;
    logic [DATA_ADDR_WIDTH-1:0]   tap_off_s;
    logic [CH_W-1:0]              ch_next_s;

    assign lstg_s = instr_r[LSTG_BIT];
    assign upse_s = instr_r[UPSE_BIT];
    assign len_s  = instr_r[LEN_LSB +: LEN_WIDTH];
    assign doff_s = instr_r[DOFF_LSB +: DATA_ADDR_WIDTH];
    assign cptr_s = instr_r[CPTR_LSB +: COEF_ADDR_WIDTH];
    assign rd_s   = instr_r[RD_LSB +: REGFILE_ADDR_WIDTH];

    // prog outside IDLE aborts the run and takes priority over everything else
    assign abort_s    = prog && (state_r != S_IDLE);
    assign last_pc_s  = (pc_r == PC_W'(INSTR_DEPTH - 1));
    assign last_tap_s = (k_r == (len_s - LEN_WIDTH'(1)));
    assign cur_wptr_s = wptr_r[ch_r];
    // Newest sample sits at wptr-1; doff and the tap index walk back in time
    assign tap_off_s  = cur_wptr_s - DATA_ADDR_WIDTH'(1) - doff_s - DATA_ADDR_WIDTH'(k_r);
    assign ch_next_s  = (ch_r == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : (ch_r + CH_W'(1));
    // Running off the end of memory without lstg behaves like lstg (err is flagged)
    assign eoi_state_s = (lstg_s || last_pc_s) ? S_OUT : S_FETCH;
    assign busy = (state_r != S_IDLE);
    assign err  = err_r;

    // Instruction memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (rst && (state_r == S_IDLE) && prog && prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; en=0 freezes every running state except the OUT handshake
    always_comb begin
        next_state_s = state_r;
        end_instr_s  = 1'b0;
        if (abort_s) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (en && !prog) next_state_s = S_FETCH;
                    else             next_state_s = S_IDLE;
                end
                S_FETCH: begin
                    if (en) next_state_s = S_DECODE;
                    else    next_state_s = S_FETCH;
                end
                S_DECODE: begin
                    if (!en) begin
                        next_state_s = S_DECODE;
                    end else if (len_s == LEN_WIDTH'(0)) begin
                        end_instr_s  = 1'b1;
                        next_state_s = eoi_state_s;
                    end else if (upse_s) begin
                        next_state_s = S_WAIT_IN;
                    end else begin
                        next_state_s = S_MAC;
                    end
                end
                S_WAIT_IN: begin
                    if (en && in_valid) next_state_s = S_MAC;
                    else                next_state_s = S_WAIT_IN;
                end
                S_MAC: begin
                    if (en && last_tap_s) next_state_s = S_STORE;
                    else                  next_state_s = S_MAC;
                end
                S_STORE: begin
                    if (en) begin
                        end_instr_s  = 1'b1;
                        next_state_s = eoi_state_s;
                    end else begin
                        next_state_s = S_STORE;
                    end
                end
                S_OUT: begin
                    // A presented result must complete its handshake even while stalled
                    if (out_ready) next_state_s = S_FETCH;
                    else           next_state_s = S_OUT;
                end
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // Sequencer datapath: pc, channel, tap counter, write pointers, sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r    <= {PC_W{1'b0}};
            ch_r    <= {CH_W{1'b0}};
            k_r     <= {LEN_WIDTH{1'b0}};
            err_r   <= 1'b0;
            instr_r <= {INSTR_WIDTH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_r[i] <= {DATA_ADDR_WIDTH{1'b0}};
            end
        end else if (abort_s) begin
            pc_r <= {PC_W{1'b0}};
            ch_r <= {CH_W{1'b0}};
            k_r  <= {LEN_WIDTH{1'b0}};
        end else begin
            if (state_r == S_FETCH) begin
                instr_r <= mem_r[pc_r];
            end
            if (state_r == S_DECODE) begin
                k_r <= {LEN_WIDTH{1'b0}};
            end
            if ((state_r == S_MAC) && en) begin
                k_r <= last_tap_s ? {LEN_WIDTH{1'b0}} : (k_r + LEN_WIDTH'(1));
            end
            if ((state_r == S_WAIT_IN) && en && in_valid) begin
                wptr_r[ch_r] <= cur_wptr_s + DATA_ADDR_WIDTH'(1);
            end
            if (end_instr_s && !lstg_s) begin
                if (last_pc_s) err_r <= 1'b1;
                else           pc_r  <= pc_r + PC_W'(1);
            end
            if ((state_r == S_OUT) && out_ready) begin
                pc_r <= {PC_W{1'b0}};
                ch_r <= ch_next_s;
            end
        end
    end

    // Output decode from state; strobes suppressed while stalled or aborting
    always_comb begin
        in_ready  = 1'b0;
        ram_wr    = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        data_addr = {(CH_W + DATA_ADDR_WIDTH){1'b0}};
        coef_addr = {COEF_ADDR_WIDTH{1'b0}};
        rf_we     = 1'b0;
        rf_addr   = {REGFILE_ADDR_WIDTH{1'b0}};
        out_valid = 1'b0;
        out_ch    = {CH_W{1'b0}};
        case (state_r)
            S_WAIT_IN: begin
                if (en && !prog) begin
                    in_ready  = 1'b1;
                    ram_wr    = in_valid;
                    data_addr = {ch_r, cur_wptr_s};
                end else begin
                    in_ready = 1'b0;
                end
            end
            S_MAC: begin
                if (en && !prog) begin
                    mac_en    = 1'b1;
                    mac_clr   = (k_r == LEN_WIDTH'(0));
                    data_addr = {ch_r, tap_off_s};
                    coef_addr = cptr_s + COEF_ADDR_WIDTH'(k_r);
                end else begin
                    mac_en = 1'b0;
                end
            end
            S_STORE: begin
                if (en && !prog) begin
                    rf_we   = 1'b1;
                    rf_addr = rd_s;
                end else begin
                    rf_we = 1'b0;
                end
            end
            S_OUT: begin
                if (!prog) begin
                    out_valid = 1'b1;
                    out_ch    = ch_r;
                end else begin
                    out_valid = 1'b0;
                end
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq_mc.sv
// Scoreboard bench for ctrl_seq_mc: a program-level reference model expands
// each channel pass into the expected stream of sample writes, MAC taps,
// register-file writes and results; a monitor pops and compares as the DUT
// presents strobes under randomized en / in_valid / out_ready.
module tb_ctrl_seq_mc;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int IW     = 22;
    localparam int BUDGET = 8000;

    typedef struct {
        int lstg; int upse; int len; int doff; int cptr; int rd;
    } instr_t;

    // kind: 0 sample write, 1 MAC tap, 2 regfile write, 3 result
    typedef struct {
        int kind; int a; int b; int c;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst, en, prog, prog_we;
    logic [3:0]    prog_addr;
    logic [IW-1:0] prog_data;
    logic          in_valid, in_ready, ram_wr, mac_en, mac_clr;
    logic [6:0]    data_addr;
    logic [5:0]    coef_addr;
    logic          rf_we;
    logic [2:0]    rf_addr;
    logic          out_valid, out_ready;
    logic [0:0]    out_ch;
    logic          busy, err;

    instr_t pmem [DEPTH];
    ev_t    exp_q [$];
    int     wp [NUM_CH];
    int     err_exp;
    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;

    ctrl_seq_mc dut (
        .clk(clk), .rst(rst), .en(en), .prog(prog), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .in_valid(in_valid), .in_ready(in_ready), .ram_wr(ram_wr),
        .mac_en(mac_en), .mac_clr(mac_clr), .data_addr(data_addr),
        .coef_addr(coef_addr), .rf_we(rf_we), .rf_addr(rf_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL timeout %s: DUT did not reach expected point within budget", nm);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [IW-1:0] pack(input instr_t i);
        return {1'(i.lstg), 1'(i.upse), 5'(i.len), 6'(i.doff), 6'(i.cptr), 3'(i.rd)};
    endfunction

    // Reference model: one full pass of the program on channel c
    task automatic model_pass(input int c);
        instr_t ins;
        ev_t    e;
        for (int pc = 0; pc < DEPTH; pc++) begin
            ins = pmem[pc];
            if (ins.len != 0) begin
                if (ins.upse != 0) begin
                    e = '{0, c * 64 + wp[c], 0, 0};
                    exp_q.push_back(e);
                    wp[c] = (wp[c] + 1) & 63;
                end
                for (int k = 0; k < ins.len; k++) begin
                    e = '{1, c * 64 + ((wp[c] - 1 - ins.doff - k) & 63),
                          (ins.cptr + k) & 63, (k == 0) ? 1 : 0};
                    exp_q.push_back(e);
                end
                e = '{2, ins.rd, 0, 0};
                exp_q.push_back(e);
            end
            if (ins.lstg != 0) break;
            if (pc == DEPTH - 1) err_exp = 1;
        end
        e = '{3, 0, 0, c};
        exp_q.push_back(e);
    endtask

    task automatic mon_pop(input string nm, input int kind, input int a, input int b, input int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected strobe a=%0h b=%0h c=%0d with empty queue", nm, a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
                errors++;
                $display("FAIL %s: got kind=%0d a=%0h b=%0h c=%0d expected kind=%0d a=%0h b=%0h c=%0d",
                         nm, kind, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    // Monitor: compares every strobe the DUT presents against the scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            if (ram_wr) mon_pop("ram_wr", 0, int'(data_addr), 0, 0);
            if (mac_en) mon_pop("mac_tap", 1, int'(data_addr), int'(coef_addr), int'(mac_clr));
            if (mac_clr && !mac_en) chk("mac_clr_alone", mac_clr, 0);
            if (rf_we)  mon_pop("rf_we", 2, int'(rf_addr), 0, 0);
            if (out_valid) begin
                if (out_ready) begin
                    mon_pop("out_hs", 3, 0, 0, int'(out_ch));
                end else if (exp_q.size() == 0) begin
                    chk("out_valid_unexpected", out_valid, 0);
                end else begin
                    chk("out_held_kind", exp_q[0].kind, 3);
                    chk("out_held_ch", out_ch, exp_q[0].c);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; prog = 1'b0; prog_we = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) wp[i] = 0;
        err_exp = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ram_wr"}, ram_wr, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_mac_clr"}, mac_clr, 0);
        chk({tag, "_data_addr"}, data_addr, 0);
        chk({tag, "_coef_addr"}, coef_addr, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_addr"}, rf_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_ch"}, out_ch, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic load_prog(input int n);
        @(posedge clk);
        #1;
        prog = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = pack(pmem[i]);
            @(posedge clk);
            #1;
        end
        prog_we = 1'b0; prog = 1'b0;
    endtask

    task automatic rand_prog(input int n, input int maxlen, input bit never_last);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) pmem[i].lstg = never_last ? 0 : 1;
            else            pmem[i].lstg = never_last ? 0 : (($urandom_range(3) == 0) ? 1 : 0);
            pmem[i].upse = int'($urandom_range(1));
            pmem[i].len  = int'($urandom_range(maxlen));
            pmem[i].doff = int'($urandom_range(63));
            pmem[i].cptr = int'($urandom_range(63));
            pmem[i].rd   = int'($urandom_range(7));
        end
    endtask

    // Run npass full passes with random stalls, then park in the next OUT and abort
    task automatic run_passes(input int npass, input int en_pct, input string nm);
        int hs;
        int cyc;
        bit seen;
        for (int p = 0; p <= npass; p++) model_pass(p % NUM_CH);
        hs = 0;
        cyc = 0;
        while (hs < npass) begin
            @(posedge clk);
            #1;
            prog = 1'b0;
            en = ($urandom_range(99) < en_pct);
            in_valid = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            cyc++;
            if (cyc > BUDGET) timeout(nm);
        end
        seen = 1'b0;
        while (!seen) begin
            @(posedge clk);
            #1;
            en = ($urandom_range(99) < en_pct);
            in_valid = 1'($urandom_range(1));
            out_ready = 1'b0;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            cyc++;
            if (cyc > BUDGET) timeout(nm);
        end
        // Hold the result with out_ready low while en toggles
        repeat (5) begin
            @(posedge clk);
            #1;
            en = 1'($urandom_range(1));
            @(negedge clk);
        end
        chk({nm, "_out_still_valid"}, out_valid, 1);
        @(posedge clk);
        #1;
        prog = 1'b1; en = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({nm, "_abort_busy"}, busy, 0);
        chk({nm, "_pending"}, exp_q.size(), 1);
        chk({nm, "_err"}, err, err_exp);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        do_reset();
        mon_on = 1'b1;
        check_reset_outputs("reset");

        // Single-instruction program, both channels
        pmem[0] = '{1, 1, 4, 0, 8, 3};
        load_prog(1);
        run_passes(4, 75, "single");

        // Two instructions, coefficient wrap on the second vector
        pmem[0] = '{0, 1, 2, 0, 0, 1};
        pmem[1] = '{1, 0, 3, 0, 62, 2};
        load_prog(2);
        run_passes(4, 75, "two_instr");

        // Sixteen instructions without lstg: runs off the end, err sticks
        rand_prog(DEPTH, 6, 1'b1);
        load_prog(DEPTH);
        run_passes(2, 80, "run_off");

        // Abort while waiting for a sample; wptr must survive
        pmem[0] = '{1, 1, 3, 1, 5, 4};
        load_prog(1);
        @(posedge clk);
        #1;
        en = 1'b1; in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!in_ready && cyc < 50);
        chk("wait_in_ready", in_ready, 1);
        chk("wait_no_ram_wr", ram_wr, 0);
        @(posedge clk);
        #1;
        prog = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("abort_cycle_in_ready", in_ready, 0);
        chk("abort_cycle_ram_wr", ram_wr, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_wait_busy", busy, 0);
        run_passes(2, 80, "after_abort");

        // Random programs
        for (int t = 0; t < 6; t++) begin
            rand_prog(int'($urandom_range(1, 5)), 8, 1'b0);
            load_prog(5);
            run_passes(3, int'($urandom_range(50, 95)), "random");
        end

        // Reset clears err and all outputs
        do_reset();
        check_reset_outputs("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
